// File: rtl/xadc_neuron_sampler_if.sv
// xadc_neuron_sampler_if: DRP port bundle between the neuron
// sampler (master) and the XADC dynamic reconfiguration port (slave).
interface xadc_neuron_sampler_if;
    logic        drp_den;
    logic [6:0]  drp_daddr;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;

    modport master (
        output drp_den,
        output drp_daddr,
        output drp_dwe,
        output drp_di,
        input  drp_do,
        input  drp_drdy
    );

    modport slave (
        input  drp_den,
        input  drp_daddr,
        input  drp_dwe,
        input  drp_di,
        output drp_do,
        output drp_drdy
    );
endinterface

// File: rtl/xadc_neuron_sampler.sv
// xadc_neuron_sampler: reads two XADC aux channels over DRP, one pair
// per sample period, and thresholds each 12-bit code into a neuron bit.
module xadc_neuron_sampler #(
    parameter logic [6:0] CH0_ADDR    = 7'h10,
    parameter logic [6:0] CH1_ADDR    = 7'h11,
    parameter int         DRP_TIMEOUT = 255
) (
    input  logic                         S_AXI_ACLK,
    input  logic                         S_AXI_ARESETN,
    input  logic [31:0]                  xadc_config,
    xadc_neuron_sampler_if.master        drp,
    output logic [1:0]                   network_output,
    output logic                         sample_valid,
    output logic                         timeout_err
);

    localparam logic [15:0] TMO = 16'(DRP_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_UPDATE,
        S_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;

    logic [11:0] r_thr;
    logic [11:0] r_code0;
    logic [15:0] r_per;
    logic [15:0] r_hold;
    logic [15:0] r_wait;
    logic [6:0]  r_daddr;
    logic [1:0]  r_net;
    logic        r_valid;
    logic        r_err;

    logic        w_en;
    logic        w_drdy;
    logic [11:0] w_thr;
    logic [15:0] w_per;
    logic [11:0] w_code;
    logic [15:0] w_wait_nx;
    logic [15:0] w_per_eff;
    logic        w_tmo;
    logic        w_hold_done;
    logic        w_latch;
    logic        w_clr_err;
    logic        w_unused;

    assign w_en        = xadc_config[0];
    assign w_thr       = xadc_config[15:4];
    assign w_per       = xadc_config[31:16];
    assign w_code      = drp.drp_do[15:4];
    assign w_drdy      = drp.drp_drdy;
    assign w_wait_nx   = r_wait + 16'd1;
    assign w_tmo       = (w_wait_nx >= TMO);
    assign w_per_eff   = (r_per == 16'd0) ? 16'd1 : r_per;
    assign w_hold_done = (r_hold <= 16'd1);
    assign w_unused    = ^{xadc_config[3:1], drp.drp_do[3:0]};

    // config is sampled only when a new pair is about to start
    assign w_latch = w_en &&
                     ((r_state == S_IDLE) ||
                      ((r_state == S_HOLD) && w_hold_done));
    assign w_clr_err = w_en && (r_state == S_IDLE);

    // state register
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // next-state logic for the two-channel read sequence
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_en) w_state_nx = S_REQ0;
            end
            S_REQ0: w_state_nx = S_WAIT0;
            S_WAIT0: begin
                if (w_drdy)     w_state_nx = S_REQ1;
                else if (w_tmo) w_state_nx = S_HOLD;
            end
            S_REQ1: w_state_nx = S_WAIT1;
            S_WAIT1: begin
                if (w_drdy)     w_state_nx = S_UPDATE;
                else if (w_tmo) w_state_nx = S_HOLD;
            end
            S_UPDATE: w_state_nx = S_HOLD;
            S_HOLD: begin
                if (w_hold_done) begin
                    w_state_nx = w_en ? S_REQ0 : S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // datapath: config latch, codes, counters, outputs
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_thr   <= '0;
            r_per   <= '0;
            r_code0 <= '0;
            r_hold  <= '0;
            r_wait  <= '0;
            r_daddr <= '0;
            r_net   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_latch) begin
                r_thr <= w_thr;
                r_per <= w_per;
            end
            if (w_clr_err) r_err <= 1'b0;
            if (w_state_nx == S_REQ0) r_daddr <= CH0_ADDR;
            if (w_state_nx == S_REQ1) r_daddr <= CH1_ADDR;
            if ((w_state_nx == S_HOLD) && (r_state != S_HOLD)) begin
                r_hold <= w_per_eff;
            end
            unique case (r_state)
                S_REQ0, S_REQ1: begin
                    r_wait <= '0;
                end
                S_WAIT0: begin
                    if (w_drdy) begin
                        r_code0 <= w_code;
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wait <= w_wait_nx;
                    end
                end
                S_WAIT1: begin
                    if (w_drdy) begin
                        r_net   <= {(w_code >= r_thr), (r_code0 >= r_thr)};
                        r_valid <= 1'b1;
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wait <= w_wait_nx;
                    end
                end
                S_HOLD: begin
                    if (!w_hold_done) r_hold <= r_hold - 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign drp.drp_den   = (r_state == S_REQ0) || (r_state == S_REQ1);
    assign drp.drp_daddr = r_daddr;
    assign drp.drp_dwe   = 1'b0;
    assign drp.drp_di    = 16'h0000;

    assign network_output = r_net;
    assign sample_valid   = r_valid;
    assign timeout_err    = r_err;

endmodule

// File: tb/tb_xadc_neuron_sampler.sv
// tb_xadc_neuron_sampler: directed bench with a small DRP responder model,
// a vector table of threshold cases and sequences for timing corners.
module tb_xadc_neuron_sampler;

    localparam logic [6:0] CH0 = 7'h10;
    localparam logic [6:0] CH1 = 7'h11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cfg;
    logic [1:0]  net;
    logic        valid;
    logic        err;

    int          checks = 0;
    int          errors = 0;

    int          rsp_dly = 2;
    bit          drop1 = 1'b0;
    int          spur_cnt = 0;
    logic [15:0] d0 = 16'h0;
    logic [15:0] d1 = 16'h0;

    xadc_neuron_sampler_if drp ();

    xadc_neuron_sampler #(
        .CH0_ADDR    (CH0),
        .CH1_ADDR    (CH1),
        .DRP_TIMEOUT (255)
    ) dut (
        .S_AXI_ACLK     (clk),
        .S_AXI_ARESETN  (rst_n),
        .xadc_config    (cfg),
        .drp            (drp),
        .network_output (net),
        .sample_valid   (valid),
        .timeout_err    (err)
    );

    always #5 clk = ~clk;

    // DRP responder: drdy rsp_dly cycles after den, driven just after posedge
    initial begin
        bit pend;
        bit sel1;
        int cnt;
        int spur_seen;
        pend = 1'b0;
        sel1 = 1'b0;
        cnt = 0;
        spur_seen = 0;
        drp.drp_drdy = 1'b0;
        drp.drp_do = 16'h0;
        forever begin
            @(posedge clk);
            #2;
            drp.drp_drdy = 1'b0;
            if (pend) begin
                if (cnt <= 1) begin
                    drp.drp_drdy = 1'b1;
                    drp.drp_do = sel1 ? d1 : d0;
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (spur_cnt != spur_seen) begin
                spur_seen = spur_cnt;
                drp.drp_drdy = 1'b1;
                drp.drp_do = 16'hFFF0;
            end
            if (drp.drp_den) begin
                sel1 = (drp.drp_daddr == CH1);
                pend = !(sel1 && drop1);
                cnt = rsp_dly;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_den(input logic [6:0] a, input int budget,
                            output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (drp.drp_den && drp.drp_daddr == a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cfg = 32'h0;
        drop1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] cfg;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        bit ok;
        int n;
        int vc;
        int dc;
        int rc;
        int gap;

        vecs[0] = '{32'h0002_8001, 16'h9000, 16'h7000, 2'b01};
        vecs[1] = '{32'h0002_8001, 16'h8000, 16'h8000, 2'b11};
        vecs[2] = '{32'h0002_FFF1, 16'hFFE0, 16'hFFE0, 2'b00};
        vecs[3] = '{32'h0002_FFF1, 16'hFFF0, 16'hFFEF, 2'b01};
        vecs[4] = '{32'h0001_0001, 16'h0000, 16'h000F, 2'b11};
        vecs[5] = '{32'h0000_123F, 16'h1230, 16'h1220, 2'b01};
        vecs[6] = '{32'h0002_8001, 16'h7FF0, 16'h8000, 2'b10};

        rst_n = 1'b0;
        cfg = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_den", drp.drp_den, 1'b0);
        check("rst_daddr", drp.drp_daddr, 7'h0);
        check("rst_net", net, 2'b00);
        check("rst_valid", valid, 1'b0);
        check("rst_err", err, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_den", drp.drp_den, 1'b0);
        check("dwe_tied", drp.drp_dwe, 1'b0);
        check("di_tied", drp.drp_di, 16'h0);

        // threshold vector table
        rsp_dly = 2;
        foreach (vecs[i]) begin
            cfg = vecs[i].cfg;
            d0 = vecs[i].d0;
            d1 = vecs[i].d1;
            wait_valid(600, ok);
            check($sformatf("vec%0d_valid", i), ok, 1'b1);
            check($sformatf("vec%0d_net", i), net, vecs[i].exp);
        end

        // latency and period: thr 0x800, period 16
        do_reset();
        rsp_dly = 3;
        d0 = 16'h9000;
        d1 = 16'h7000;
        cfg = 32'h0010_8001;
        n = -100;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (drp.drp_drdy && drp.drp_daddr == CH1) n = k;
            if (valid) begin
                ok = 1'b1;
                n = k - n;
                break;
            end
        end
        check("lat_valid_seen", ok, 1'b1);
        check("lat_drdy_to_valid", n, 1);
        check("lat_net", net, 2'b01);
        vc = 0;
        gap = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (valid) vc++;
            if (drp.drp_den) begin
                gap = k + 1;
                break;
            end
        end
        check("period16_hold_cycles", gap - 1, 16);
        check("valid_one_cycle", vc, 0);
        check("den_addr_ch0", drp.drp_daddr, CH0);
        @(negedge clk);
        check("den_one_cycle", drp.drp_den, 1'b0);
        check("daddr_held", drp.drp_daddr, CH0);

        // CH1 never answers: timeout
        do_reset();
        rsp_dly = 2;
        d0 = 16'h8000;
        d1 = 16'h8000;
        cfg = 32'h0004_8001;
        wait_valid(100, ok);
        check("to_pre_valid", ok, 1'b1);
        check("to_pre_net", net, 2'b11);
        drop1 = 1'b1;
        wait_den(CH1, 100, ok);
        check("to_den1_seen", ok, 1'b1);
        n = 0;
        vc = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (err) break;
            if (valid) vc++;
            n++;
        end
        check("to_wait_cycles", n, 255);
        check("to_err_set", err, 1'b1);
        check("to_net_kept", net, 2'b11);
        check("to_no_valid", vc, 0);
        drop1 = 1'b0;
        d1 = 16'h7000;
        wait_valid(100, ok);
        check("to_resume_valid", ok, 1'b1);
        check("to_resume_net", net, 2'b01);
        check("to_err_sticky", err, 1'b1);
        cfg = 32'h0004_8000;
        dc = 0;
        repeat (30) begin
            @(negedge clk);
            if (drp.drp_den) dc++;
        end
        check("to_idle_no_den", dc, 0);
        check("to_err_idle", err, 1'b1);
        cfg = 32'h0004_8001;
        @(negedge clk);
        check("to_err_cleared", err, 1'b0);
        check("to_fresh_den", drp.drp_den, 1'b1);

        // enable dropped during a pair, config changed mid-pair
        do_reset();
        rsp_dly = 2;
        d0 = 16'h9000;
        d1 = 16'h9000;
        cfg = 32'h0004_8001;
        wait_den(CH0, 20, ok);
        check("mid_den0_seen", ok, 1'b1);
        cfg = 32'h0004_FFF0;
        vc = 0;
        dc = 0;
        repeat (80) begin
            @(negedge clk);
            if (valid) vc++;
            if (drp.drp_den) dc++;
        end
        check("mid_one_valid", vc, 1);
        check("mid_only_req1", dc, 1);
        check("mid_old_thr_net", net, 2'b11);
        check("mid_idle_den", drp.drp_den, 1'b0);

        // period 0 with spurious drdy in HOLD
        do_reset();
        rsp_dly = 1;
        d0 = 16'h7000;
        d1 = 16'h7000;
        cfg = 32'h0000_8001;
        for (int r = 0; r < 2; r++) begin
            wait_valid(50, ok);
            check($sformatf("p0_valid%0d", r), ok, 1'b1);
            check($sformatf("p0_net%0d", r), net, 2'b00);
            spur_cnt++;
            gap = 0;
            vc = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (valid) vc++;
                if (drp.drp_den) begin
                    gap = k + 1;
                    break;
                end
            end
            check($sformatf("p0_gap%0d", r), gap, 2);
            check($sformatf("p0_spur_ignored%0d", r), vc, 0);
        end

        // reset during WAIT1, late drdy afterwards
        do_reset();
        rsp_dly = 5;
        d0 = 16'h8000;
        d1 = 16'h8000;
        cfg = 32'h0001_8001;
        wait_valid(100, ok);
        check("rw_pre_net", net, 2'b11);
        wait_den(CH1, 100, ok);
        check("rw_den1_seen", ok, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        cfg = 32'h0;
        #1;
        check("rw_den", drp.drp_den, 1'b0);
        check("rw_daddr", drp.drp_daddr, 7'h0);
        check("rw_net", net, 2'b00);
        check("rw_valid", valid, 1'b0);
        check("rw_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        vc = 0;
        dc = 0;
        rc = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid) vc++;
            if (drp.drp_den) dc++;
            if (drp.drp_drdy) rc++;
        end
        check("rw_late_drdy_issued", rc, 1);
        check("rw_no_valid", vc, 0);
        check("rw_no_den", dc, 0);
        check("rw_net_after", net, 2'b00);
        cfg = 32'h0001_8001;
        wait_den(CH0, 5, ok);
        check("rw_enable_restarts", ok, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xadc_neuron_sampler.md
XADC_NEURON_SAMPLER -- requirements
Module: xadc_neuron_sampler

Interface
REQ-001 SHALL have parameter CH0_ADDR, default 7'h10: DRP address of the neuron-0 output channel (VAUX0).
REQ-002 SHALL have parameter CH1_ADDR, default 7'h11: DRP address of the neuron-1 output channel (VAUX1).
REQ-003 SHALL have parameter DRP_TIMEOUT, default 255: maximum number of cycles to wait for drp_drdy after a request.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: S_AXI_ACLK  in  1  clock; S_AXI_ARESETN  in  1  reset.
REQ-005 SHALL have port xadc_config  in  32: [0] enable, [15:4] 12-bit threshold, [31:16] sample period in cycles; bits [3:1] ignored.
REQ-006 SHALL have port drp_den  out  1: DRP request strobe.
REQ-007 SHALL have port drp_daddr  out  7: DRP address.
REQ-008 SHALL have port drp_dwe  out  1: DRP write enable, tied 0.
REQ-009 SHALL have port drp_di  out  16: DRP write data, tied 0.
REQ-010 SHALL have port drp_do  in  16: DRP read data; the ADC code is in [15:4].
REQ-011 SHALL have port drp_drdy  in  1: DRP read-data-valid strobe.
REQ-012 SHALL have port network_output  out  2: bit n = 1 when the neuron-n code is greater than or equal to the threshold.
REQ-013 SHALL have port sample_valid  out  1: one-cycle pulse when network_output updates.
REQ-014 SHALL have port timeout_err  out  1: sticky DRP timeout flag.

Function
REQ-015 SHALL implement states IDLE, REQ0, WAIT0, REQ1, WAIT1, UPDATE, HOLD.
REQ-016 IDLE: SHALL go to REQ0 on the first clock edge at which xadc_config[0]=1, and SHALL latch the threshold and period on that edge.
REQ-017 REQ0/REQ1: SHALL assert drp_den for exactly one cycle with drp_daddr=CH0_ADDR or CH1_ADDR, then go to WAIT0 or WAIT1.
REQ-018 drp_daddr SHALL hold its value until the next request.
REQ-019 WAIT0/WAIT1: on drp_drdy=1, SHALL capture drp_do[15:4] into code0 or code1 and go to REQ1 or UPDATE.
REQ-020 drp_drdy SHALL be ignored in every state other than WAIT0/WAIT1.
REQ-021 In WAIT0/WAIT1, a wait counter SHALL reset to 0 on entry and count each cycle without drp_drdy.
REQ-022 When the wait counter reaches DRP_TIMEOUT, the block SHALL set timeout_err, abandon the pair without updating network_output, and go to HOLD.
REQ-023 UPDATE: SHALL register network_output={code1>=thr, code0>=thr} (unsigned 12-bit compare), pulse sample_valid for 1 cycle, then go to HOLD.
REQ-024 Latency from drp_drdy of channel 1 to network_output/sample_valid SHALL be exactly 1 cycle.
REQ-025 HOLD: SHALL load the period counter with the latched period and stay max(period,1) cycles; a period of 0 SHALL behave as 1.
REQ-026 On HOLD exit, if xadc_config[0]=1 the block SHALL relatch threshold/period and go to REQ0, else go to IDLE.
REQ-027 Clearing enable mid-pair SHALL NOT abort the pair; the pair SHALL complete (or time out), and the block SHALL return to IDLE after HOLD.
REQ-028 Changes to xadc_config during a pair SHALL NOT affect that pair.
REQ-029 timeout_err SHALL clear only on reset, or on an IDLE-to-REQ0 transition (fresh enable), and never otherwise.
REQ-030 drp_den SHALL never be asserted while a request is outstanding: at most one outstanding request.
REQ-031 network_output SHALL hold its last value while in IDLE and HOLD.

Reset
REQ-032 On S_AXI_ARESETN=0, asynchronously: state=IDLE, drp_den=0, drp_daddr=0, network_output=2'b00, sample_valid=0, timeout_err=0, all counters and codes 0.
REQ-033 Reset asserted mid-pair SHALL deassert drp_den immediately; a drp_drdy arriving after reset release SHALL be ignored.
REQ-034 The first request after reset release SHALL require enable to be seen in IDLE.

Verification
REQ-035 xadc_config=32'h0010_8001 (thr 0x800, period 16), DRP model returns 16'h9000 then 16'h7000, drdy 3 cycles after den -> network_output=2'b01, sample_valid pulse 1 cycle after 2nd drdy, next den 16 cycles after UPDATE.
REQ-036 Codes equal to thr (16'h8000 both, thr 0x800) -> network_output=2'b11; thr 0xFFF with codes 0xFFE -> 2'b00.
REQ-037 DRP model never asserts drdy on CH1 -> timeout_err=1 after 255 wait cycles, network_output unchanged, no sample_valid, sampling resumes after HOLD; clearing then setting enable clears timeout_err.
REQ-038 Enable cleared 1 cycle after REQ0 -> pair completes, one sample_valid, block in IDLE with drp_den=0 thereafter.
REQ-039 Period field 0 -> successive REQ0 strobes exactly 1 HOLD cycle apart from UPDATE; spurious drdy in HOLD ignored.
REQ-040 S_AXI_ARESETN low during WAIT1 -> all outputs at reset values same cycle; late drdy after release produces no update.
